// File: rtl/mem_stage.sv
// Memory-access stage: drives the data bus with a req/ack handshake,
// stalls upstream while an access is outstanding, produces MEM/WB.
module mem_stage #(
   parameter int GPR_WIDTH  = 32,
   parameter int PC_WIDTH   = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_mem_write_enable,
   input  logic [1:0]            in_wb_res_mux,
   input  logic                  in_reg_write_enable,
   input  logic [3:0]            in_reg_dest,
   input  logic [GPR_WIDTH-1:0]  in_alu_res,
   input  logic [GPR_WIDTH-1:0]  in_mem_addr,
   input  logic [GPR_WIDTH-1:0]  in_mem_data,
   input  logic [GPR_WIDTH-1:0]  in_imm,
   input  logic [PC_WIDTH-1:0]   in_next_pc,
   input  logic [PC_WIDTH-1:0]   in_branch_addr,
   input  logic                  in_branch_taken,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [GPR_WIDTH-1:0]  dmem_wdata,
   input  logic [GPR_WIDTH-1:0]  dmem_rdata,
   input  logic                  dmem_ack,
   output logic                  stall,
   output logic                  pc_redirect,
   output logic [PC_WIDTH-1:0]   pc_target,
   output logic [GPR_WIDTH-1:0]  ex_mem_fwd_data,
   output logic                  bus_error,
   output logic                  out_reg_write_enable,
   output logic [1:0]            out_wb_res_mux,
   output logic [3:0]            out_reg_dest,
   output logic [GPR_WIDTH-1:0]  out_alu_res,
   output logic [GPR_WIDTH-1:0]  out_mem_rdata,
   output logic [GPR_WIDTH-1:0]  out_imm,
   output logic [PC_WIDTH-1:0]   out_next_pc
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

   typedef struct packed {
      logic                 rwe;
      logic [1:0]           mux;
      logic [3:0]           dest;
      logic [GPR_WIDTH-1:0] alu;
      logic [GPR_WIDTH-1:0] rdata;
      logic [GPR_WIDTH-1:0] imm;
      logic [PC_WIDTH-1:0]  npc;
   } wb_t;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   wb_t                   wb_q, wb_d;
   wb_t                   hold_q, hold_d;
   logic                  kill_q, kill_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [GPR_WIDTH-1:0]  wdata_q, wdata_d;
   logic                  berr_q, berr_d;
   logic                  mem_op;
   wb_t                   in_wb;

   assign mem_op = in_mem_write_enable |
                   (in_reg_write_enable & (in_wb_res_mux == 2'b01));

   assign in_wb = '{rwe:   in_reg_write_enable,
                    mux:   in_wb_res_mux,
                    dest:  in_reg_dest,
                    alu:   in_alu_res,
                    rdata: '0,
                    imm:   in_imm,
                    npc:   in_next_pc};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wb_d    = '0;
      hold_d  = hold_q;
      kill_d  = kill_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      berr_d  = berr_q;
      unique case (state_q)
         IDLE: begin
            if (mem_op) begin
               hold_d  = in_wb;
               kill_d  = 1'b0;
               req_d   = 1'b1;
               we_d    = in_mem_write_enable;
               addr_d  = in_mem_addr[ADDR_WIDTH-1:0];
               wdata_d = in_mem_data;
               cnt_d   = '0;
               state_d = WAIT;
            end else begin
               wb_d = in_wb;
            end
         end
         WAIT: begin
            if (dmem_ack) begin
               hold_d.rdata = we_q ? '0 : dmem_rdata;
               req_d        = 1'b0;
               we_d         = 1'b0;
               state_d      = DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               berr_d  = 1'b1;
               kill_d  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            // inputs here are the stale instruction already being retired
            if (!kill_q) wb_d = hold_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wb_q    <= '0;
         hold_q  <= '0;
         kill_q  <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wb_q    <= wb_d;
         hold_q  <= hold_d;
         kill_q  <= kill_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         berr_q  <= berr_d;
      end
   end

   assign stall           = ((state_q == IDLE) & mem_op) | (state_q == WAIT);
   assign pc_redirect     = in_branch_taken;
   assign pc_target       = in_branch_addr;
   assign ex_mem_fwd_data = in_alu_res;
   assign bus_error       = berr_q;
   assign dmem_req        = req_q;
   assign dmem_we         = we_q;
   assign dmem_addr       = addr_q;
   assign dmem_wdata      = wdata_q;

   assign out_reg_write_enable = wb_q.rwe;
   assign out_wb_res_mux       = wb_q.mux;
   assign out_reg_dest         = wb_q.dest;
   assign out_alu_res          = wb_q.alu;
   assign out_mem_rdata        = wb_q.rdata;
   assign out_imm              = wb_q.imm;
   assign out_next_pc          = wb_q.npc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load, store, timeout,
// branch redirect and reset during an outstanding access.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_mem_write_enable;
   logic [1:0]  in_wb_res_mux;
   logic        in_reg_write_enable;
   logic [3:0]  in_reg_dest;
   logic [31:0] in_alu_res, in_mem_addr, in_mem_data, in_imm;
   logic [31:0] in_next_pc, in_branch_addr;
   logic        in_branch_taken;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        stall, pc_redirect;
   logic [31:0] pc_target, ex_mem_fwd_data;
   logic        bus_error;
   logic        out_reg_write_enable;
   logic [1:0]  out_wb_res_mux;
   logic [3:0]  out_reg_dest;
   logic [31:0] out_alu_res, out_mem_rdata, out_imm, out_next_pc;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .in_mem_write_enable(in_mem_write_enable),
      .in_wb_res_mux(in_wb_res_mux),
      .in_reg_write_enable(in_reg_write_enable),
      .in_reg_dest(in_reg_dest),
      .in_alu_res(in_alu_res),
      .in_mem_addr(in_mem_addr),
      .in_mem_data(in_mem_data),
      .in_imm(in_imm),
      .in_next_pc(in_next_pc),
      .in_branch_addr(in_branch_addr),
      .in_branch_taken(in_branch_taken),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall(stall), .pc_redirect(pc_redirect),
      .pc_target(pc_target), .ex_mem_fwd_data(ex_mem_fwd_data),
      .bus_error(bus_error),
      .out_reg_write_enable(out_reg_write_enable),
      .out_wb_res_mux(out_wb_res_mux),
      .out_reg_dest(out_reg_dest),
      .out_alu_res(out_alu_res),
      .out_mem_rdata(out_mem_rdata),
      .out_imm(out_imm),
      .out_next_pc(out_next_pc)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nop();
      in_mem_write_enable = 0;
      in_wb_res_mux       = 0;
      in_reg_write_enable = 0;
      in_reg_dest         = 0;
      in_alu_res          = 0;
      in_mem_addr         = 0;
      in_mem_data         = 0;
      in_imm              = 0;
      in_next_pc          = 0;
      in_branch_addr      = 0;
      in_branch_taken     = 0;
   endtask

   task automatic load(input logic [31:0] a, input logic [3:0] d);
      nop();
      in_wb_res_mux       = 2'b01;
      in_reg_write_enable = 1;
      in_reg_dest         = d;
      in_mem_addr         = a;
      in_alu_res          = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1;
      dmem_ack   = 0;
      dmem_rdata = 0;
      nop();
      #12;
      check("rst_req", dmem_req, 0);
      check("rst_stall", stall, 0);
      check("rst_berr", bus_error, 0);
      check("rst_wb_rwe", out_reg_write_enable, 0);
      @(negedge clk);
      rst = 0;

      // ALU pass-through
      in_alu_res          = 32'h1234;
      in_reg_dest         = 5;
      in_reg_write_enable = 1;
      in_imm              = 32'h77;
      in_next_pc          = 32'h21;
      #1;
      check("alu_stall", stall, 0);
      check("alu_fwd", ex_mem_fwd_data, 32'h1234);
      tick();
      check("alu_res", out_alu_res, 32'h1234);
      check("alu_dest", out_reg_dest, 5);
      check("alu_rwe", out_reg_write_enable, 1);
      check("alu_imm", out_imm, 32'h77);
      check("alu_npc", out_next_pc, 32'h21);
      check("alu_rdata", out_mem_rdata, 0);
      nop();

      // load, ack in 2nd WAIT cycle
      @(negedge clk);
      load(32'h40, 3);
      #1;
      check("ld_stall0", stall, 1);
      tick();
      check("ld_req1", dmem_req, 1);
      check("ld_we1", dmem_we, 0);
      check("ld_addr1", dmem_addr, 32'h40);
      check("ld_stall1", stall, 1);
      check("ld_bubble1", out_reg_write_enable, 0);
      tick();
      check("ld_req2", dmem_req, 1);
      check("ld_addr2", dmem_addr, 32'h40);
      check("ld_stall2", stall, 1);
      dmem_ack   = 1;
      dmem_rdata = 32'hDEADBEEF;
      tick();
      dmem_ack   = 0;
      dmem_rdata = 0;
      check("ld_req3", dmem_req, 0);
      check("ld_stall3", stall, 0);
      check("ld_bubble3", out_reg_write_enable, 0);
      tick();
      check("ld_rdata", out_mem_rdata, 32'hDEADBEEF);
      check("ld_dest", out_reg_dest, 3);
      check("ld_rwe", out_reg_write_enable, 1);
      check("ld_mux", out_wb_res_mux, 1);
      nop();

      // store, ack in 1st WAIT cycle, spurious ack afterwards
      @(negedge clk);
      in_mem_write_enable = 1;
      in_mem_addr         = 32'h10;
      in_mem_data         = 32'hCAFEF00D;
      in_alu_res          = 32'h10;
      #1;
      check("st_stall0", stall, 1);
      tick();
      check("st_req1", dmem_req, 1);
      check("st_we1", dmem_we, 1);
      check("st_addr1", dmem_addr, 32'h10);
      check("st_wdata1", dmem_wdata, 32'hCAFEF00D);
      check("st_stall1", stall, 1);
      dmem_ack   = 1;
      dmem_rdata = 32'h11111111;
      tick();
      check("st_req2", dmem_req, 0);
      check("st_stall2", stall, 0);
      tick();
      check("st_rwe", out_reg_write_enable, 0);
      check("st_rdata", out_mem_rdata, 0);
      check("st_alu", out_alu_res, 32'h10);
      nop();
      tick();
      check("spur_req", dmem_req, 0);
      check("spur_stall", stall, 0);
      dmem_ack   = 0;
      dmem_rdata = 0;

      // branch redirect
      @(negedge clk);
      in_branch_taken = 1;
      in_branch_addr  = 32'h200;
      #1;
      check("br_redir", pc_redirect, 1);
      check("br_target", pc_target, 32'h200);
      check("br_stall", stall, 0);
      @(negedge clk);
      nop();
      #1;
      check("br_clear", pc_redirect, 0);

      // timeout, no ack
      @(negedge clk);
      load(32'h80, 7);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("to_req%0d", i), dmem_req, 1);
         check($sformatf("to_berr%0d", i), bus_error, 0);
      end
      tick();
      check("to_req_drop", dmem_req, 0);
      check("to_berr", bus_error, 1);
      check("to_stall", stall, 0);
      tick();
      check("to_rwe", out_reg_write_enable, 0);
      check("to_dest", out_reg_dest, 0);
      check("to_alu", out_alu_res, 0);
      nop();
      tick();
      tick();
      check("to_sticky", bus_error, 1);

      // reset during WAIT, then a late ack
      @(negedge clk);
      load(32'h44, 2);
      tick();
      check("rw_req", dmem_req, 1);
      tick();
      #2;
      rst = 1;
      #1;
      check("rw_req0", dmem_req, 0);
      check("rw_addr0", dmem_addr, 0);
      check("rw_berr0", bus_error, 0);
      check("rw_rwe0", out_reg_write_enable, 0);
      nop();
      @(negedge clk);
      rst        = 0;
      dmem_ack   = 1;
      dmem_rdata = 32'h5555AAAA;
      tick();
      tick();
      check("late_req", dmem_req, 0);
      check("late_stall", stall, 0);
      check("late_rdata", out_mem_rdata, 0);
      check("late_rwe", out_reg_write_enable, 0);
      dmem_ack = 0;
      @(negedge clk);
      in_alu_res          = 32'hABCD;
      in_reg_dest         = 9;
      in_reg_write_enable = 1;
      tick();
      check("post_alu", out_alu_res, 32'hABCD);
      check("post_dest", out_reg_dest, 9);
      nop();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
